// File: rtl/i2f48_pipe.sv
// i2f48_pipe: 3-stage pipelined 48-bit integer to fp48 converter with valid/ready flow control.
// Define I2F48_RM_EN to add the rm port and the directed rounding modes; the default build is RNE only.
module i2f48_pipe #(
   parameter int WID  = 48,
   parameter int EXPW = 11,
   parameter int BIAS = 1023
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           op,
   input  logic [WID-1:0] i,
`ifdef I2F48_RM_EN
   input  logic [2:0]     rm,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [WID-1:0] o,
   output logic           inexact
);
   localparam int MW  = WID - EXPW;   // kept mantissa bits, hidden bit included
   localparam int GB  = WID - MW - 1; // guard bit position in the normalized magnitude
   localparam int LZW = $clog2(WID + 1);

   function automatic logic [LZW-1:0] lzc(input logic [WID-1:0] v);
      logic [LZW-1:0] n;
      logic           found;
      n     = {LZW{1'b0}};
      found = 1'b0;
      for (int k = WID - 1; k >= 0; k--) begin
         found = found | v[k];
         n     = n + {{(LZW-1){1'b0}}, ~found};
      end
      return n;
   endfunction

   logic           adv_s;
   logic           sgn_s;
   logic [WID-1:0] mag_s;

   logic           v1_r, sgn1_r, zero1_r;
   logic [WID-1:0] mag1_r;
   logic           v2_r, sgn2_r, zero2_r;
   logic [WID-1:0] nm2_r;
   logic [EXPW-1:0] e2_r;
`ifdef I2F48_RM_EN
   logic [2:0]     rm1_r, rm2_r;
`endif

   logic [LZW-1:0]  lz_s;
   logic [WID-1:0]  nm_s;
   logic [EXPW-1:0] e_s;

   logic [MW-1:0]   mant_s;
   logic            g_s, st_s, inx_s, inc_s;
   logic [MW:0]     sum_s;
   logic [EXPW-1:0] ex_s;
   logic [MW-2:0]   frac_s;
   logic [WID-1:0]  res_s;
   logic            resx_s;

   assign adv_s    = ~out_valid | out_ready;
   assign in_ready = adv_s;

   assign sgn_s = op & i[WID-1];
   assign mag_s = sgn_s ? (~i + {{(WID-1){1'b0}}, 1'b1}) : i;

   // Stage 1: capture sign, magnitude and zero flag of the accepted operand.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r    <= 1'b0;
         sgn1_r  <= 1'b0;
         zero1_r <= 1'b0;
         mag1_r  <= {WID{1'b0}};
`ifdef I2F48_RM_EN
         rm1_r   <= 3'd0;
`endif
      end else if (adv_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            sgn1_r  <= sgn_s;
            zero1_r <= (i == {WID{1'b0}});
            mag1_r  <= mag_s;
`ifdef I2F48_RM_EN
            rm1_r   <= rm;
`endif
         end
      end
   end

   assign lz_s = lzc(mag1_r);
   assign nm_s = mag1_r << lz_s;
   assign e_s  = EXPW'(BIAS + WID - 1) - {{(EXPW-LZW){1'b0}}, lz_s};

   // Stage 2: normalized magnitude and unrounded biased exponent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r    <= 1'b0;
         sgn2_r  <= 1'b0;
         zero2_r <= 1'b0;
         nm2_r   <= {WID{1'b0}};
         e2_r    <= {EXPW{1'b0}};
`ifdef I2F48_RM_EN
         rm2_r   <= 3'd0;
`endif
      end else if (adv_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            sgn2_r  <= sgn1_r;
            zero2_r <= zero1_r;
            nm2_r   <= nm_s;
            e2_r    <= e_s;
`ifdef I2F48_RM_EN
            rm2_r   <= rm1_r;
`endif
         end
      end
   end

   // Stage 3 datapath: rounding increment, carry renormalization and packing.
   always_comb begin
      mant_s = nm2_r[WID-1 -: MW];
      g_s    = nm2_r[GB];
      st_s   = |nm2_r[GB-1:0];
      inx_s  = g_s | st_s;
`ifdef I2F48_RM_EN
      case (rm2_r)
         3'd1:    inc_s = 1'b0;
         3'd2:    inc_s = sgn2_r & inx_s;
         3'd3:    inc_s = ~sgn2_r & inx_s;
         3'd4:    inc_s = g_s;
         default: inc_s = g_s & (st_s | mant_s[0]);
      endcase
`else
      inc_s = g_s & (st_s | mant_s[0]);
`endif
      sum_s = {1'b0, mant_s} + {{MW{1'b0}}, inc_s};
      if (sum_s[MW]) begin
         frac_s = sum_s[MW-1:1];
         ex_s   = e2_r + {{(EXPW-1){1'b0}}, 1'b1};
      end else begin
         frac_s = sum_s[MW-2:0];
         ex_s   = e2_r;
      end
      if (zero2_r) begin
         res_s  = {WID{1'b0}};
         resx_s = 1'b0;
      end else begin
         res_s  = {sgn2_r, ex_s, frac_s};
         resx_s = inx_s;
      end
   end

   // Stage 3 register: the result is held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         o         <= {WID{1'b0}};
         inexact   <= 1'b0;
      end else if (adv_s) begin
         out_valid <= v2_r;
         if (v2_r) begin
            o       <= res_s;
            inexact <= resx_s;
         end
      end
   end
endmodule

// File: tb/tb_i2f48_pipe.sv
// tb_i2f48_pipe: directed vectors for i2f48_pipe, checked against an arithmetic fp48 model
// through a scoreboard, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_i2f48_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        op = 1'b0;
   logic [47:0] i = 48'd0;
   logic [2:0]  rm_s = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [47:0] o;
   logic        inexact;

   int nvec = 0;
   int nerr = 0;
   logic [48:0] expq[$];

   i2f48_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .i(i),
`ifdef I2F48_RM_EN
      .rm(rm_s),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .o(o), .inexact(inexact)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Returns {inexact, fp48} from exact integer arithmetic on the operand value.
   function automatic logic [48:0] model(input logic opv, input logic [47:0] iv, input logic [2:0] rmv);
      longint unsigned mag, q, r, half;
      int p, sh;
      logic sgn, inx, up;
      sgn = opv & iv[47];
      mag = sgn ? ((64'd1 << 48) - {16'd0, iv}) : {16'd0, iv};
      if (mag == 64'd0) return 49'd0;
      p = 0;
      while ((mag >> (p + 1)) != 64'd0) p++;
      if (p <= 36) begin
         q = mag << (36 - p); r = 64'd0; half = 64'd0; sh = 0;
      end else begin
         sh = p - 36; q = mag >> sh; r = mag - (q << sh); half = 64'd1 << (sh - 1);
      end
      inx = (r != 64'd0);
      case (rmv)
         3'd1:    up = 1'b0;
         3'd2:    up = sgn & inx;
         3'd3:    up = ~sgn & inx;
         3'd4:    up = (sh > 0) && (r >= half);
         default: up = (sh > 0) && ((r > half) || ((r == half) && q[0]));
      endcase
      q = q + {63'd0, up};
      if (q == (64'd1 << 37)) begin
         q = q >> 1;
         p++;
      end
      return {inx, sgn, 11'(1023 + p), q[35:0]};
   endfunction

   // Scoreboard and stall-stability checks, sampled on the falling edge.
   logic        hold_v = 1'b0;
   logic [47:0] hold_o = 48'd0;
   logic        hold_x = 1'b0;
   always @(negedge clk) begin
      logic [48:0] e;
      if (!rst_n) begin
         expq.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_o", {16'd0, o}, {16'd0, hold_o});
            chk("stall_inexact", {63'd0, inexact}, {63'd0, hold_x});
         end
         if (in_valid && in_ready) expq.push_back(model(op, i, rm_s));
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL spurious: got o=%h with nothing outstanding", o);
            end else begin
               e = expq.pop_front();
               chk("o", {16'd0, o}, {16'd0, e[47:0]});
               chk("inexact", {63'd0, inexact}, {63'd0, e[48]});
            end
         end
         hold_v = out_valid & ~out_ready;
         hold_o = o;
         hold_x = inexact;
      end
   end

   // Latency counts cycles from the accepting cycle to the first cycle with out_valid high.
   task automatic single(input logic opv, input logic [47:0] iv, input logic [2:0] rmv,
                         input logic [47:0] eo, input logic ex, input string name);
      int n;
      @(posedge clk); #1;
      op = opv; i = iv; rm_s = rmv; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'd3);
      chk({name, "_o"}, {16'd0, o}, {16'd0, eo});
      chk({name, "_inexact"}, {63'd0, inexact}, {63'd0, ex});
   endtask

   logic [48:0] svec[8];
   initial begin
      int idx, cyc, g;
      logic acc;
      svec = '{ {1'b0, 48'h0000_0000_0001}, {1'b1, 48'hFFFF_FFFF_FFFF}, {1'b0, 48'h0020_0000_0003},
                {1'b0, 48'h0000_0000_0000}, {1'b1, 48'h8000_0000_0000}, {1'b0, 48'h1234_5678_9ABC},
                {1'b1, 48'hFEDC_BA98_7654}, {1'b0, 48'h0000_0000_00FF} };

      chk("model_one", {15'd0, model(1'b1, 48'd1, 3'd0)}, {15'd0, 1'b0, 48'h3FF0_0000_0000});
      chk("model_tie_even", {15'd0, model(1'b0, 48'h0020_0000_0001, 3'd0)}, {15'd0, 1'b1, 48'h4240_0000_0000});
      chk("model_tie_up", {15'd0, model(1'b0, 48'h0020_0000_0003, 3'd0)}, {15'd0, 1'b1, 48'h4240_0000_0002});
      chk("model_carry", {15'd0, model(1'b0, 48'hFFFF_FFFF_FFFF, 3'd0)}, {15'd0, 1'b1, 48'h42F0_0000_0000});

      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_o", {16'd0, o}, 64'd0);
      chk("rst_inexact", {63'd0, inexact}, 64'd0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      single(1'b1, 48'h0000_0000_0001, 3'd0, 48'h3FF0_0000_0000, 1'b0, "s_one");
      single(1'b1, 48'hFFFF_FFFF_FFFF, 3'd0, 48'hBFF0_0000_0000, 1'b0, "s_neg1");
      single(1'b0, 48'hFFFF_FFFF_FFFF, 3'd0, 48'h42F0_0000_0000, 1'b1, "u_max");
      single(1'b0, 48'h0020_0000_0001, 3'd0, 48'h4240_0000_0000, 1'b1, "tie_even");
      single(1'b0, 48'h0020_0000_0003, 3'd0, 48'h4240_0000_0002, 1'b1, "tie_up");
      single(1'b0, 48'h0000_0000_0000, 3'd0, 48'h0000_0000_0000, 1'b0, "u_zero");
      single(1'b1, 48'h0000_0000_0000, 3'd0, 48'h0000_0000_0000, 1'b0, "s_zero");
      single(1'b1, 48'h8000_0000_0000, 3'd0, 48'hC2E0_0000_0000, 1'b0, "s_min");
      single(1'b0, 48'h8000_0000_0000, 3'd0, 48'h42E0_0000_0000, 1'b0, "u_top");
      single(1'b1, 48'hFFFF_FFFF_FFFD, 3'd0, 48'hC008_0000_0000, 1'b0, "s_neg3");
      single(1'b0, 48'h0040_0000_0001, 3'd0, 48'h4250_0000_0000, 1'b1, "below_half");
      single(1'b0, 48'h0040_0000_0003, 3'd0, 48'h4250_0000_0001, 1'b1, "above_half");
`ifdef I2F48_RM_EN
      single(1'b0, 48'h0020_0000_0003, 3'd1, 48'h4240_0000_0001, 1'b1, "rtz");
      single(1'b1, 48'hFFDF_FFFF_FFFF, 3'd2, 48'hC240_0000_0001, 1'b1, "rdn_neg");
      single(1'b1, 48'hFFDF_FFFF_FFFF, 3'd3, 48'hC240_0000_0000, 1'b1, "rup_neg");
      single(1'b0, 48'h0020_0000_0001, 3'd3, 48'h4240_0000_0001, 1'b1, "rup_pos");
      single(1'b0, 48'h0020_0000_0001, 3'd4, 48'h4240_0000_0001, 1'b1, "rmm");
      single(1'b0, 48'h0020_0000_0003, 3'd7, 48'h4240_0000_0002, 1'b1, "rm7_rne");
      rm_s = 3'd0;
`endif

      // Back-to-back stream with the consumer stalling every other cycle.
      @(posedge clk); #1;
      idx = 0; cyc = 0;
      in_valid = 1'b1; op = svec[0][48]; i = svec[0][47:0]; out_ready = 1'b0;
      while (idx < 8 && cyc < 200) begin
         @(negedge clk);
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         if (idx < 8) begin
            op = svec[idx][48]; i = svec[idx][47:0];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ~out_ready;
         cyc++;
      end
      chk("stream_accept_count", 64'(idx), 64'd8);
      out_ready = 1'b1;
      g = 0;
      while ((expq.size() != 0 || out_valid) && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      chk("stream_drain", 64'(expq.size()), 64'd0);

      // Reset with three operands in flight.
      out_ready = 1'b0;
      in_valid = 1'b1; op = 1'b0; i = 48'h0000_0000_0005;
      @(posedge clk); #1 i = 48'h0000_0000_0006;
      @(posedge clk); #1 i = 48'h0000_0000_0007;
      @(posedge clk); #1 in_valid = 1'b0;
      chk("inflight_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_o", {16'd0, o}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      #1 chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
      end
      chk("leftover", 64'(expq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
